// File: rtl/lift_call_queue_if.sv
// Hall-call queue <-> controller/button-side signal bundle.
// master: drives button pulses and completion; slave: the queue itself.
// Ports: btn, lift_done (to queue); req_code, q_empty, q_count, lamp (from queue).
interface lift_call_queue_if;
  logic [5:0] btn;
  logic       lift_done;
  logic [2:0] req_code;
  logic       q_empty;
  logic [3:0] q_count;
  logic [5:0] lamp;

  modport master (
    output btn, lift_done,
    input  req_code, q_empty, q_count, lamp
  );

  modport slave (
    input  btn, lift_done,
    output req_code, q_empty, q_count, lamp
  );
endinterface

// File: rtl/lift_call_queue.sv
// Hall-call capture, dedup and FIFO for the lift controller.
// Latency: press to lamp 1 cycle, press to req_code >= 2 cycles; one enqueue and one pop per edge.
// Backpressure: a full FIFO leaves calls in pending (lamp lit) until a pop frees a slot.
// Ports: clk, rst (sync, active high), bus (slave modport: btn, lift_done in;
//        req_code, q_empty, q_count, lamp out).
module lift_call_queue #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  lift_call_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [3:0]    count_q, count_d;
  logic [5:0]    pending_q, pending_d;
  logic [5:0]    queued_q, queued_d;

  logic [2:0] head_code;
  logic       empty;
  logic       pop;
  logic       enq;
  logic [2:0] enq_idx;
  logic [5:0] enq_mask;
  logic [5:0] pop_mask;
  logic [5:0] queued_after_pop;

  assign empty     = (count_q == 4'd0);
  assign head_code = mem_q[rptr_q];
  assign pop       = bus.lift_done && !empty;

  // Lowest set index of the registered pending set wins the single enqueue slot.
  always_comb begin
    enq_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) enq_idx = 3'(i);
    end
  end

  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign enq      = (pending_q != 6'd0) && ((count_q != 4'(DEPTH)) || pop);
  assign enq_mask = enq ? (6'b000001 << enq_idx) : 6'd0;
  // Valid heads are codes 1..6, so code-1 is the call index being retired.
  assign pop_mask = pop ? (6'b000001 << (head_code - 3'd1)) : 6'd0;

  assign queued_after_pop = queued_q & ~pop_mask;

  always_comb begin
    // A press is dropped if the call is already waiting anywhere after this
    // edge's pop; a call retired on this edge may therefore be re-captured.
    pending_d = (pending_q & ~enq_mask) | (bus.btn & ~(pending_q | queued_after_pop));
    queued_d  = queued_after_pop | enq_mask;
    wptr_d    = enq ? AW'(wptr_q + 1'b1) : wptr_q;
    rptr_d    = pop ? AW'(rptr_q + 1'b1) : rptr_q;
    count_d   = count_q;
    if (enq && !pop)      count_d = count_q + 4'd1;
    else if (!enq && pop) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= 4'd0;
      pending_q <= 6'd0;
      queued_q  <= 6'd0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      queued_q  <= queued_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[wptr_q] <= enq_idx + 3'd1;
  end

  assign bus.req_code = empty ? 3'd0 : head_code;
  assign bus.q_empty  = empty;
  assign bus.q_count  = count_q;
  assign bus.lamp     = pending_q | queued_q;
endmodule

// File: tb/tb_lift_call_queue.sv
module tb_lift_call_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lift_call_queue_if bus();

  lift_call_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of codes plus a set of waiting call indices.
  int   mq[$];
  logic mp [6];

  function automatic logic [2:0] m_code();
    if (mq.size() == 0) return 3'd0;
    return 3'(mq[0]);
  endfunction

  function automatic logic [5:0] m_lamp();
    logic [5:0] l;
    for (int i = 0; i < 6; i++) l[i] = mp[i];
    foreach (mq[k]) l[mq[k]-1] = 1'b1;
    return l;
  endfunction

  function automatic bit in_fifo(int code);
    foreach (mq[k]) if (mq[k] == code) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, then
  // leave outputs settled 1 time unit after the edge for sampling.
  task automatic step(input logic [5:0] b, input logic d, input logic r);
    logic old_p [6];
    int   low;
    bus.btn       = b;
    bus.lift_done = d;
    rst           = r;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      for (int i = 0; i < 6; i++) mp[i] = 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) old_p[i] = mp[i];
      if (d && mq.size() > 0) void'(mq.pop_front());
      for (int i = 0; i < 6; i++)
        if (b[i] && !old_p[i] && !in_fifo(i + 1)) mp[i] = 1'b1;
      low = -1;
      for (int i = 5; i >= 0; i--) if (old_p[i]) low = i;
      if (low >= 0 && mq.size() < DEPTH) begin
        mq.push_back(low + 1);
        mp[low] = 1'b0;
      end
    end
    bus.btn       = 6'd0;
    bus.lift_done = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      step(6'd0, 1'b0, c < 2);
      tests++;
      if (bus.req_code !== 3'd0 || bus.q_empty !== 1'b1 || bus.q_count !== 4'd0 || bus.lamp !== 6'd0) begin
        fails++;
        $display("FAIL reset_idle c%0d: got code=%0d empty=%0b count=%0d lamp=%b, want 0/1/0/000000",
                 c, bus.req_code, bus.q_empty, bus.q_count, bus.lamp);
      end
    end
  endtask

  task automatic test_single_call();
    step(6'b000010, 1'b0, 1'b0);
    tests++;
    if (bus.lamp !== 6'b000010 || bus.q_count !== 4'd0) begin
      fails++;
      $display("FAIL single_lamp: got lamp=%b count=%0d, want 000010/0", bus.lamp, bus.q_count);
    end
    step(6'd0, 1'b0, 1'b0);
    tests++;
    if (bus.req_code !== 3'd2 || bus.q_count !== 4'd1 || bus.q_empty !== 1'b0) begin
      fails++;
      $display("FAIL single_enq: got code=%0d count=%0d empty=%0b, want 2/1/0", bus.req_code, bus.q_count, bus.q_empty);
    end
    // Re-press on the retiring edge must be captured again.
    step(6'b000010, 1'b1, 1'b0);
    tests++;
    if (bus.lamp !== 6'b000010 || bus.q_count !== 4'd0 || bus.req_code !== 3'd0) begin
      fails++;
      $display("FAIL press_on_pop: got lamp=%b count=%0d code=%0d, want 000010/0/0", bus.lamp, bus.q_count, bus.req_code);
    end
    step(6'd0, 1'b0, 1'b0);
    tests++;
    if (bus.req_code !== 3'd2 || bus.q_count !== 4'd1) begin
      fails++;
      $display("FAIL press_on_pop_enq: got code=%0d count=%0d, want 2/1", bus.req_code, bus.q_count);
    end
    step(6'd0, 1'b1, 1'b0);
    tests++;
    if (bus.req_code !== 3'd0 || bus.q_empty !== 1'b1 || bus.lamp !== 6'd0) begin
      fails++;
      $display("FAIL single_pop: got code=%0d empty=%0b lamp=%b, want 0/1/000000", bus.req_code, bus.q_empty, bus.lamp);
    end
    // Popping an empty queue does nothing.
    step(6'd0, 1'b1, 1'b0);
    tests++;
    if (bus.q_count !== 4'd0 || bus.q_empty !== 1'b1) begin
      fails++;
      $display("FAIL empty_pop: got count=%0d empty=%0b, want 0/1", bus.q_count, bus.q_empty);
    end
  endtask

  task automatic test_multi_press();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd1; exp_codes[1] = 3'd3; exp_codes[2] = 3'd6;
    step(6'b100101, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(6'd0, 1'b0, 1'b0);
      tests++;
      if (bus.q_count !== 4'(k + 1) || bus.req_code !== 3'd1) begin
        fails++;
        $display("FAIL multi_fill k%0d: got count=%0d code=%0d, want %0d/1", k, bus.q_count, bus.req_code, k + 1);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (bus.req_code !== exp_codes[k]) begin
        fails++;
        $display("FAIL multi_order k%0d: got code=%0d, want %0d", k, bus.req_code, exp_codes[k]);
      end
      step(6'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_dedup();
    step(6'b010000, 1'b0, 1'b0);
    step(6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(6'b010000, 1'b0, 1'b0);
      tests++;
      if (bus.q_count !== 4'd1 || bus.req_code !== 3'd5 || bus.lamp !== 6'b010000) begin
        fails++;
        $display("FAIL dedup k%0d: got count=%0d code=%0d lamp=%b, want 1/5/010000", k, bus.q_count, bus.req_code, bus.lamp);
      end
    end
    step(6'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(6'd0, 1'b0, 1'b0);
      tests++;
      if (bus.q_count !== 4'd0 || bus.req_code !== 3'd0) begin
        fails++;
        $display("FAIL dedup_drain k%0d: got count=%0d code=%0d, want 0/0", k, bus.q_count, bus.req_code);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_cnt [6];
    exp_cnt[0] = 4; exp_cnt[1] = 4; exp_cnt[2] = 3; exp_cnt[3] = 2; exp_cnt[4] = 1; exp_cnt[5] = 0;
    step(6'b111111, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(6'd0, 1'b0, 1'b0);
      tests++;
      if (bus.q_count !== 4'((k < 4) ? k + 1 : 4) || bus.lamp !== 6'b111111) begin
        fails++;
        $display("FAIL bp_fill k%0d: got count=%0d lamp=%b, want %0d/111111", k, bus.q_count, bus.lamp, (k < 4) ? k + 1 : 4);
      end
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (bus.req_code !== 3'(k + 1)) begin
        fails++;
        $display("FAIL bp_head k%0d: got code=%0d, want %0d", k, bus.req_code, k + 1);
      end
      step(6'd0, 1'b1, 1'b0);
      tests++;
      if (bus.q_count !== 4'(exp_cnt[k])) begin
        fails++;
        $display("FAIL bp_count k%0d: got count=%0d, want %0d", k, bus.q_count, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(6'b011111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(6'd0, 1'b0, 1'b0);
    tests++;
    if (bus.q_count !== 4'd3 || bus.lamp !== 6'b011111) begin
      fails++;
      $display("FAIL mid_setup: got count=%0d lamp=%b, want 3/011111", bus.q_count, bus.lamp);
    end
    step(6'b100000, 1'b1, 1'b1);
    tests++;
    if (bus.q_empty !== 1'b1 || bus.req_code !== 3'd0 || bus.lamp !== 6'd0 || bus.q_count !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset: got empty=%0b code=%0d lamp=%b count=%0d, want 1/0/000000/0",
               bus.q_empty, bus.req_code, bus.lamp, bus.q_count);
    end
    step(6'b000001, 1'b0, 1'b0);
    tests++;
    if (bus.lamp !== 6'b000001 || bus.q_count !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_press: got lamp=%b count=%0d, want 000001/0", bus.lamp, bus.q_count);
    end
    step(6'd0, 1'b0, 1'b0);
    tests++;
    if (bus.req_code !== 3'd1 || bus.q_count !== 4'd1) begin
      fails++;
      $display("FAIL post_reset_enq: got code=%0d count=%0d, want 1/1", bus.req_code, bus.q_count);
    end
    step(6'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] b;
    logic       d, r;
    for (int c = 0; c < 400; c++) begin
      b = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      d = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(b, d, r);
      tests++;
      if (bus.req_code !== m_code() || bus.q_count !== 4'(mq.size()) ||
          bus.lamp !== m_lamp() || bus.q_empty !== (mq.size() == 0)) begin
        fails++;
        $display("FAIL random c%0d: got code=%0d count=%0d lamp=%b empty=%0b, want %0d/%0d/%b/%0b",
                 c, bus.req_code, bus.q_count, bus.lamp, bus.q_empty,
                 m_code(), mq.size(), m_lamp(), mq.size() == 0);
      end
    end
  endtask

  initial begin
    bus.btn       = 6'd0;
    bus.lift_done = 1'b0;
    for (int i = 0; i < 6; i++) mp[i] = 1'b0;
    test_reset();
    test_single_call();
    test_multi_press();
    test_dedup();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
